// File: rtl/enemy_control.sv
// Enemy sprite controller: spawns an enemy, walks it one pixel per step toward a
// target base, and handles interception (explosion phase) and arrival (one-clk pulse).
module enemy_control #(
  parameter int OUT_WIDTH    = 8,
  parameter int X_SPAWN      = 255,
  parameter int Y_SPAWN      = 0,
  parameter int X_TARGET     = 64,
  parameter int Y_TARGET     = 128,
  parameter int X_PARK       = 0,
  parameter int STEP_DIV     = 2,
  parameter int DESTROY_TIME = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 spawn,
  input  logic                 hit,
  output logic [OUT_WIDTH-1:0] xenemy,
  output logic [OUT_WIDTH-1:0] yenemy,
  output logic                 enemy_active,
  output logic                 enemy_destroyed,
  output logic                 enemy_arrived
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_FLYING    = 3'd2;
  localparam logic [2:0] S_DESTROYED = 3'd3;
  localparam logic [2:0] S_ARRIVED   = 3'd4;

  localparam logic [OUT_WIDTH-1:0] X_SPAWN_C  = OUT_WIDTH'(X_SPAWN);
  localparam logic [OUT_WIDTH-1:0] Y_SPAWN_C  = OUT_WIDTH'(Y_SPAWN);
  localparam logic [OUT_WIDTH-1:0] X_TARGET_C = OUT_WIDTH'(X_TARGET);
  localparam logic [OUT_WIDTH-1:0] Y_TARGET_C = OUT_WIDTH'(Y_TARGET);
  localparam logic [OUT_WIDTH-1:0] X_PARK_C   = OUT_WIDTH'(X_PARK);

  // One counter serves both the step divider and the explosion timer.
  localparam int CNT_MAX = (STEP_DIV > DESTROY_TIME) ? STEP_DIV : DESTROY_TIME;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] DESTROY_LAST = CNT_W'(DESTROY_TIME - 1);

  logic [2:0]           state_q, state_d;
  logic [OUT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 active_q, active_d;
  logic                 destroyed_q, destroyed_d;
  logic                 arrived_q, arrived_d;
  logic [OUT_WIDTH-1:0] step_x, step_y;

  // Each axis moves one unit toward its target and never overshoots.
  always_comb begin
    if (x_q > X_TARGET_C)      step_x = x_q - OUT_WIDTH'(1);
    else if (x_q < X_TARGET_C) step_x = x_q + OUT_WIDTH'(1);
    else                       step_x = x_q;
    if (y_q > Y_TARGET_C)      step_y = y_q - OUT_WIDTH'(1);
    else if (y_q < Y_TARGET_C) step_y = y_q + OUT_WIDTH'(1);
    else                       step_y = y_q;
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        state_d = S_IDLE;
        x_d     = X_PARK_C;
        y_d     = Y_SPAWN_C;
        cnt_d   = '0;
      end
      S_IDLE: begin
        x_d   = X_PARK_C;
        y_d   = Y_SPAWN_C;
        cnt_d = '0;
        if (spawn) begin
          state_d = S_FLYING;
          x_d     = X_SPAWN_C;
        end
      end
      S_FLYING: begin
        // A hit freezes the enemy where it is, even on its final step.
        if (hit) begin
          state_d = S_DESTROYED;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            x_d   = step_x;
            y_d   = step_y;
            if (step_x == X_TARGET_C && step_y == Y_TARGET_C) state_d = S_ARRIVED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DESTROYED: begin
        if (frame_tick) begin
          if (cnt_q == DESTROY_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            x_d     = X_PARK_C;
            y_d     = Y_SPAWN_C;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ARRIVED: begin
        state_d = S_IDLE;
        x_d     = X_PARK_C;
        y_d     = Y_SPAWN_C;
      end
      default: begin
        state_d = S_RESET;
        x_d     = X_PARK_C;
        y_d     = Y_SPAWN_C;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register alongside it.
  always_comb begin
    active_d    = (state_d == S_FLYING);
    destroyed_d = (state_d == S_DESTROYED);
    arrived_d   = (state_d == S_ARRIVED);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
    if (rst) begin
      state_q     <= S_RESET;
      x_q         <= X_PARK_C;
      y_q         <= Y_SPAWN_C;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      destroyed_q <= 1'b0;
      arrived_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      destroyed_q <= destroyed_d;
      arrived_q   <= arrived_d;
    end
  end

  assign xenemy          = x_q;
  assign yenemy          = y_q;
  assign enemy_active    = active_q;
  assign enemy_destroyed = destroyed_q;
  assign enemy_arrived   = arrived_q;

endmodule

// File: tb/tb_enemy_control.sv
// Self-checking bench for enemy_control: directed scenarios plus random stimulus,
// compared each clock against a flight model built from step counts and distances.
module tb_enemy_control;

  localparam int W   = 8;
  localparam int XS  = 255;
  localparam int YS  = 0;
  localparam int XT  = 64;
  localparam int YT  = 128;
  localparam int XP  = 0;
  localparam int SD  = 2;
  localparam int DT  = 3;

  localparam int P_RST = 0, P_IDLE = 1, P_FLY = 2, P_DEAD = 3, P_ARR = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_tick = 1'b0;
  logic         spawn = 1'b0;
  logic         hit = 1'b0;
  logic [W-1:0] xenemy, yenemy;
  logic         enemy_active, enemy_destroyed, enemy_arrived;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, frame ticks since spawn, ticks since hit, frozen coords.
  int m_phase = P_RST;
  int m_ticks = 0;
  int m_dead  = 0;
  int m_x     = XP;
  int m_y     = YS;

  enemy_control dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .spawn           (spawn),
    .hit             (hit),
    .xenemy          (xenemy),
    .yenemy          (yenemy),
    .enemy_active    (enemy_active),
    .enemy_destroyed (enemy_destroyed),
    .enemy_arrived   (enemy_arrived)
  );

  always #5 clk = ~clk;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int abs_i(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Position after n unit steps from start toward target, saturating at target.
  function automatic int move(input int start, input int target, input int n);
    if (start > target) return start - min_i(n, start - target);
    return start + min_i(n, target - start);
  endfunction

  function automatic int flight_len();
    int dx = abs_i(XS - XT);
    int dy = abs_i(YS - YT);
    return (dx > dy) ? dx : dy;
  endfunction

  task automatic model_step(input logic t, input logic s, input logic h, input logic r);
    if (r) begin
      m_phase = P_RST; m_ticks = 0; m_dead = 0; m_x = XP; m_y = YS;
    end else begin
      case (m_phase)
        P_RST:  m_phase = P_IDLE;
        P_IDLE: if (s) begin
          m_phase = P_FLY; m_ticks = 0; m_x = XS; m_y = YS;
        end
        P_FLY: begin
          if (h) begin
            m_phase = P_DEAD; m_dead = 0;
          end else if (t) begin
            m_ticks++;
            if (m_ticks % SD == 0) begin
              m_x = move(XS, XT, m_ticks / SD);
              m_y = move(YS, YT, m_ticks / SD);
              if (m_ticks / SD >= flight_len()) m_phase = P_ARR;
            end
          end
        end
        P_DEAD: if (t) begin
          m_dead++;
          if (m_dead == DT) m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [2*W+2:0] exp_vec();
    logic parked = (m_phase == P_IDLE) || (m_phase == P_RST);
    logic [W-1:0] ex = parked ? W'(XP) : W'(m_x);
    logic [W-1:0] ey = parked ? W'(YS) : W'(m_y);
    return {ex, ey, m_phase == P_FLY, m_phase == P_DEAD, m_phase == P_ARR};
  endfunction

  function automatic logic [2*W+2:0] dut_vec();
    return {xenemy, yenemy, enemy_active, enemy_destroyed, enemy_arrived};
  endfunction

  // Drive inputs at the falling edge, advance one clock, leave time at the next falling edge.
  task automatic run_cycle(input logic t, input logic s, input logic h, input logic r);
    frame_tick = t; spawn = s; hit = h; rst = r;
    @(posedge clk);
    model_step(t, s, h, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    run_cycle(0, 1, 1, 1);
    n_vec++;
    if (dut_vec() !== {8'd0, 8'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), {8'd0, 8'd0, 3'b000});
    end
    run_cycle(0, 1, 0, 0);  // RESET -> IDLE, spawn ignored
    n_vec++;
    if (dut_vec() !== exp_vec() || enemy_active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_to_idle: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_spawn_step();
    run_cycle(0, 1, 0, 0);
    n_vec++;
    if ({xenemy, yenemy, enemy_active} !== {8'd255, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL spawn_load: got x=%0d y=%0d act=%b want x=255 y=0 act=1", xenemy, yenemy, enemy_active);
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle(i % 2 == 0, 0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL spawn_step_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({xenemy, yenemy} !== {8'd254, 8'd1}) begin
      n_err++;
      $display("FAIL first_step: got x=%0d y=%0d want x=254 y=1", xenemy, yenemy);
    end
  endtask

  task automatic test_full_flight();
    int pulses = 0;
    int c = 0;
    bit done = 0;
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 1, 0, 0);
    while (!done && c < 4000) begin
      run_cycle(c % 4 == 3, 1, 0, 0);  // spawn held high: must be ignored in flight
      c++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL flight_cycle%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (enemy_arrived === 1'b1) begin
        pulses++;
        n_vec++;
        if ({xenemy, yenemy} !== {8'd64, 8'd128}) begin
          n_err++;
          $display("FAIL arrive_pos: got x=%0d y=%0d want x=64 y=128", xenemy, yenemy);
        end
        spawn = 0;
        run_cycle(0, 0, 0, 0);
        n_vec++;
        if ({xenemy, enemy_arrived, enemy_active} !== {8'd0, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL after_arrive: got x=%0d arr=%b act=%b want x=0 arr=0 act=0", xenemy, enemy_arrived, enemy_active);
        end
        done = 1;
      end
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL arrive_pulse_count: got %0d want 1 (cycles %0d)", pulses, c);
    end
  endtask

  task automatic test_hit_midflight();
    int arrs = 0;
    run_cycle(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) run_cycle(i % 2 == 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0);
    n_vec++;
    if ({xenemy, yenemy, enemy_active, enemy_destroyed} !== {8'd245, 8'd10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL hit_freeze: got x=%0d y=%0d act=%b des=%b want x=245 y=10 act=0 des=1", xenemy, yenemy, enemy_active, enemy_destroyed);
    end
    for (int i = 0; i < 6; i++) begin
      run_cycle(i % 2 == 0, i == 1, i == 2, 0);  // spawn and hit ignored while destroyed
      if (enemy_arrived === 1'b1) arrs++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL destroyed_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({xenemy, enemy_destroyed, arrs} !== {8'd0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL destroy_exit: got x=%0d des=%b arr_pulses=%0d want x=0 des=0 arr_pulses=0", xenemy, enemy_destroyed, arrs);
    end
  endtask

  task automatic test_hit_at_arrival();
    int arrs = 0;
    run_cycle(0, 1, 0, 0);
    for (int i = 0; i < (flight_len() * SD - 1) * 2; i++) begin
      run_cycle(i % 2 == 0, 0, 0, 0);
      if (enemy_arrived === 1'b1) arrs++;
    end
    run_cycle(1, 0, 1, 0);
    n_vec++;
    if ({xenemy, yenemy, enemy_destroyed, enemy_arrived} !== {8'd65, 8'd128, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL hit_beats_arrival: got x=%0d y=%0d des=%b arr=%b want x=65 y=128 des=1 arr=0", xenemy, yenemy, enemy_destroyed, enemy_arrived);
    end
    for (int i = 0; i < 8; i++) begin
      run_cycle(i % 2 == 0, 0, 0, 0);
      if (enemy_arrived === 1'b1) arrs++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL late_hit_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (arrs !== 0) begin
      n_err++;
      $display("FAIL no_arrival_pulse: got %0d pulses want 0", arrs);
    end
  endtask

  task automatic test_reset_midflight();
    run_cycle(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) run_cycle(1, 0, 0, 0);
    run_cycle(1, 1, 1, 1);
    n_vec++;
    if (dut_vec() !== {8'd0, 8'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_midflight: got %h want %h", dut_vec(), {8'd0, 8'd0, 3'b000});
    end
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 1, 0, 0);
    n_vec++;
    if ({xenemy, yenemy, enemy_active} !== {8'd255, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL respawn_after_reset: got x=%0d y=%0d act=%b want x=255 y=0 act=1", xenemy, yenemy, enemy_active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5000; i++) begin
      run_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 149) == 0, $urandom_range(0, 699) == 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spawn_step();
    test_full_flight();
    test_hit_midflight();
    test_hit_at_arrival();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
